slc3_input_conditioner: RTL and testbench

Front-end conditioning stage that feeds slc3_testtop on the board, between the raw DE-series pushbuttons and slide switches and the processor's Run, Continue and SW inputs.
- Synchronizes all asynchronous inputs into the Clk domain.
- Debounces the active-low Run and Continue keys.
- Emits clean active-low levels plus one-cycle press pulses.
- Lets slc3_testtop see exactly one Run/Continue event per physical press.

---
 rtl/slc3_io_pkg.sv | 19 +
 rtl/slc3_input_conditioner_key_debouncer.sv | 112 +++++++++++
 rtl/slc3_input_conditioner.sv | 57 +++++
 tb/tb_slc3_input_conditioner.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slc3_io_pkg.sv
// Shared types and constants for the SLC-3 board input conditioning path.
package slc3_io_pkg;

  // Debouncer states: a pending state means the synchronized key disagrees
  // with the stable level and the agreement run is being counted.
  typedef enum logic [1:0] {
    RELEASED,
    PRESS_PEND,
    PRESSED,
    RELEASE_PEND
  } debounce_state_t;

  // Keys are active-low, so the idle (released) level is 1.
  localparam logic KEY_RELEASED = 1'b1;

  // 10 ms at 50 MHz.
  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

endpackage

// File: rtl/slc3_input_conditioner_key_debouncer.sv
// Single-key conditioner: two-flop synchronizer, debounce FSM with run
// counter, and a one-cycle strobe when the stable level goes to pressed.
module key_debouncer
  import slc3_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic srst,
  input  logic key_raw,
  output logic level,
  output logic pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // With a single required cycle the pending states are skipped entirely.
  localparam bit SINGLE_CYCLE = (DEBOUNCE_CYCLES == 1);

  logic            sync1_reg;
  logic            sync2_reg;
  debounce_state_t state_reg;
  debounce_state_t state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic            pulse_reg;
  logic            pulse_next;

  // Bring the asynchronous key into the clock domain; clears to released.
  always_ff @(posedge clk) begin
    if (srst) begin
      sync1_reg <= KEY_RELEASED;
      sync2_reg <= KEY_RELEASED;
    end else begin
      sync1_reg <= key_raw;
      sync2_reg <= sync1_reg;
    end
  end

  // State, agreement counter and strobe registers; reset drops any partial count.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_reg <= RELEASED;
      cnt_reg   <= '0;
      pulse_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      pulse_reg <= pulse_next;
    end
  end

  // Next state: any sample agreeing with the stable level abandons the
  // pending change, so only an unbroken run of disagreement commits it.
  always_comb begin
    state_next = state_reg;
    cnt_next   = '0;
    pulse_next = 1'b0;
    case (state_reg)
      RELEASED: begin
        if (sync2_reg != KEY_RELEASED) begin
          if (SINGLE_CYCLE) begin
            state_next = PRESSED;
            pulse_next = 1'b1;
          end else begin
            state_next = PRESS_PEND;
            cnt_next   = CNT_ONE;
          end
        end
      end
      PRESS_PEND: begin
        if (sync2_reg == KEY_RELEASED) begin
          state_next = RELEASED;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = PRESSED;
          pulse_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      PRESSED: begin
        if (sync2_reg == KEY_RELEASED) begin
          if (SINGLE_CYCLE) begin
            state_next = RELEASED;
          end else begin
            state_next = RELEASE_PEND;
            cnt_next   = CNT_ONE;
          end
        end
      end
      RELEASE_PEND: begin
        if (sync2_reg != KEY_RELEASED) begin
          state_next = PRESSED;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = RELEASED;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      default: begin
        state_next = RELEASED;
      end
    endcase
  end

  // The stable level is pressed while pressed or while a release is pending.
  assign level = ((state_reg == PRESSED) || (state_reg == RELEASE_PEND)) ?
                 ~KEY_RELEASED : KEY_RELEASED;
  assign pulse = pulse_reg;

endmodule

// File: rtl/slc3_input_conditioner.sv
// Board front end for slc3_testtop: debounced Run/Continue keys with press
// strobes, and synchronized (undebounced) slide switches.
module slc3_input_conditioner
  import slc3_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int SW_WIDTH        = 10
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Run_raw,
  input  logic                Continue_raw,
  input  logic [SW_WIDTH-1:0] SW_raw,
  output logic                Run,
  output logic                Continue,
  output logic [SW_WIDTH-1:0] SW,
  output logic                Run_pulse,
  output logic                Continue_pulse
);

  logic [SW_WIDTH-1:0] sw_sync1_reg;
  logic [SW_WIDTH-1:0] sw_sync2_reg;

  // Two-flop synchronizer on every switch bit; switches are levels, not events.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sw_sync1_reg <= '0;
      sw_sync2_reg <= '0;
    end else begin
      sw_sync1_reg <= SW_raw;
      sw_sync2_reg <= sw_sync1_reg;
    end
  end

  assign SW = sw_sync2_reg;

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_run_key (
    .clk     (Clk),
    .srst    (Reset),
    .key_raw (Run_raw),
    .level   (Run),
    .pulse   (Run_pulse)
  );

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_continue_key (
    .clk     (Clk),
    .srst    (Reset),
    .key_raw (Continue_raw),
    .level   (Continue),
    .pulse   (Continue_pulse)
  );

endmodule

// File: tb/tb_slc3_input_conditioner.sv
// Bench for slc3_input_conditioner: two instances (4-cycle and 1-cycle
// debounce) share stimulus; a reference model feeds per-instance scoreboards.
module tb_slc3_input_conditioner;

  localparam int SWW = 10;

  logic           Clk = 1'b0;
  logic           Reset = 1'b1;
  logic           Run_raw = 1'b1;
  logic           Continue_raw = 1'b1;
  logic [SWW-1:0] SW_raw = '0;

  logic           run4, cont4, rp4, cp4;
  logic [SWW-1:0] sw4;
  logic           run1, cont1, rp1, cp1;
  logic [SWW-1:0] sw1;

  typedef struct packed {
    logic           run;
    logic           cont;
    logic [SWW-1:0] sw;
    logic           rp;
    logic           cp;
  } exp_t;

  exp_t q4[$];
  exp_t q1[$];
  int   checks = 0;
  int   failures = 0;
  int   rp_cnt[2] = '{0, 0};
  int   cp_cnt[2] = '{0, 0};

  always #5 Clk = ~Clk;

  slc3_input_conditioner #(.DEBOUNCE_CYCLES(4), .SW_WIDTH(SWW)) u_dut4 (
    .Clk(Clk), .Reset(Reset), .Run_raw(Run_raw), .Continue_raw(Continue_raw),
    .SW_raw(SW_raw), .Run(run4), .Continue(cont4), .SW(sw4),
    .Run_pulse(rp4), .Continue_pulse(cp4)
  );

  slc3_input_conditioner #(.DEBOUNCE_CYCLES(1), .SW_WIDTH(SWW)) u_dut1 (
    .Clk(Clk), .Reset(Reset), .Run_raw(Run_raw), .Continue_raw(Continue_raw),
    .SW_raw(SW_raw), .Run(run1), .Continue(cont1), .SW(sw1),
    .Run_pulse(rp1), .Continue_pulse(cp1)
  );

  task automatic check_val(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, req);
    end
  endtask

  function automatic logic get_level(input int sel);
    case (sel)
      0:       return run4;
      1:       return cont4;
      2:       return run1;
      default: return cont1;
    endcase
  endfunction

  // Edges from now until the selected level reads val; -1 if it never does.
  task automatic wait_level(input int sel, input logic val, output int edges);
    edges = -1;
    for (int e = 1; e <= 30; e++) begin
      @(posedge Clk);
      #1;
      if (get_level(sel) === val) begin
        edges = e;
        break;
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // Reference model: a key's stable level flips once the sample seen two edges
  // after capture has disagreed with it for DEBOUNCE_CYCLES edges in a row.
  initial begin
    logic           d1 [2];
    logic           d2 [2];
    logic           y [2];
    logic [SWW-1:0] swa, swb;
    logic           s [2][2];
    int             run [2][2];
    logic           pls [2][2];
    int             dcyc [2];
    exp_t           e;
    dcyc = '{4, 1};
    for (int k = 0; k < 2; k++) begin
      d1[k] = 1'b1;
      d2[k] = 1'b1;
      y[k]  = 1'b1;
    end
    swa = '0;
    swb = '0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        s[i][j] = 1'b1; run[i][j] = 0; pls[i][j] = 1'b0;
      end
    forever begin
      @(posedge Clk);
      if (Reset) begin
        for (int k = 0; k < 2; k++) begin
          d1[k] = 1'b1;
          d2[k] = 1'b1;
        end
        swa = '0;
        swb = '0;
        for (int i = 0; i < 2; i++)
          for (int j = 0; j < 2; j++) begin
            s[i][j] = 1'b1; run[i][j] = 0; pls[i][j] = 1'b0;
          end
      end else begin
        y[0]  = d2[0];
        y[1]  = d2[1];
        d2[0] = d1[0];
        d2[1] = d1[1];
        d1[0] = Run_raw;
        d1[1] = Continue_raw;
        swb   = swa;
        swa   = SW_raw;
        for (int i = 0; i < 2; i++)
          for (int j = 0; j < 2; j++) begin
            pls[i][j] = 1'b0;
            if (y[j] != s[i][j]) begin
              run[i][j]++;
              if (run[i][j] == dcyc[i]) begin
                s[i][j]   = y[j];
                run[i][j] = 0;
                pls[i][j] = (y[j] == 1'b0);
              end
            end else begin
              run[i][j] = 0;
            end
          end
      end
      e.run = s[0][0]; e.cont = s[0][1]; e.sw = swb; e.rp = pls[0][0]; e.cp = pls[0][1];
      q4.push_back(e);
      e.run = s[1][0]; e.cont = s[1][1]; e.sw = swb; e.rp = pls[1][0]; e.cp = pls[1][1];
      q1.push_back(e);
    end
  end

  // Monitor: every cycle presents outputs; pop the expectation and compare.
  initial begin
    exp_t e;
    exp_t a;
    forever begin
      @(negedge Clk);
      if (rp4) rp_cnt[0]++;
      if (cp4) cp_cnt[0]++;
      if (rp1) rp_cnt[1]++;
      if (cp1) cp_cnt[1]++;
      for (int i = 0; i < 2; i++) begin
        checks++;
        if ((i == 0 ? q4.size() : q1.size()) == 0) begin
          failures++;
          $display("FAIL scoreboard_empty inst=%0d t=%0t", i, $time);
        end else begin
          e = (i == 0) ? q4.pop_front() : q1.pop_front();
          a = (i == 0) ? {run4, cont4, sw4, rp4, cp4} : {run1, cont1, sw1, rp1, cp1};
          if (a !== e) begin
            failures++;
            $display("FAIL scoreboard inst=%0d t=%0t actual run=%b cont=%b sw=%h rp=%b cp=%b required run=%b cont=%b sw=%h rp=%b cp=%b",
                     i, $time, a.run, a.cont, a.sw, a.rp, a.cp, e.run, e.cont, e.sw, e.rp, e.cp);
          end
        end
      end
    end
  end

  // Stimulus with directed boundary checks, then randomized traffic.
  initial begin
    int e;
    int base_r, base_c;
    int first_edge;
    logic both;

    // Reset with a pressed key and all switches on.
    Run_raw = 1'b0;
    SW_raw  = 10'h3FF;
    tick(2);
    check_val("reset_run", int'(run4), 1);
    check_val("reset_continue", int'(cont4), 1);
    check_val("reset_sw", int'(sw4), 0);
    check_val("reset_pulses", int'({rp4, cp4}), 0);
    Reset = 1'b0;
    @(posedge Clk); #1;
    check_val("sw_after_1_edge", int'(sw4), 0);
    @(posedge Clk); #1;
    check_val("sw_after_2_edges", int'(sw4), 10'h3FF);
    tick(8);
    Run_raw = 1'b1;
    tick(12);

    // Clean press held: fall at edge 6, single pulse, nothing on release.
    base_r = rp_cnt[0];
    Run_raw = 1'b0;
    wait_level(0, 1'b0, e);
    check_val("run_fall_edge", e, 6);
    tick(20);
    check_val("run_held_level", int'(run4), 0);
    check_val("run_held_pulses", rp_cnt[0] - base_r, 1);
    Run_raw = 1'b1;
    tick(10);
    check_val("run_released_level", int'(run4), 1);
    check_val("run_release_no_pulse", rp_cnt[0] - base_r, 1);

    // Bouncy Continue never reaches four agreeing samples.
    base_c = cp_cnt[0];
    Continue_raw = 1'b0; tick(3);
    Continue_raw = 1'b1; tick(1);
    Continue_raw = 1'b0; tick(3);
    Continue_raw = 1'b1; tick(10);
    check_val("bounce_no_pulse", cp_cnt[0] - base_c, 0);
    check_val("bounce_level", int'(cont4), 1);

    // Simultaneous presses then simultaneous release.
    base_r = rp_cnt[0];
    base_c = cp_cnt[0];
    Run_raw = 1'b0;
    Continue_raw = 1'b0;
    first_edge = -1;
    both = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge Clk); #1;
      if (rp4 || cp4) begin
        first_edge = k;
        both = rp4 && cp4;
        break;
      end
    end
    check_val("dual_pulse_edge", first_edge, 6);
    check_val("dual_pulse_same_cycle", int'(both), 1);
    tick(10);
    Run_raw = 1'b1;
    Continue_raw = 1'b1;
    wait_level(0, 1'b1, e);
    check_val("dual_release_edge", e, 6);
    check_val("dual_release_continue", int'(cont4), 1);
    tick(4);
    check_val("dual_pulse_counts", (rp_cnt[0] - base_r) + (cp_cnt[0] - base_c), 2);

    // Reset in the middle of a pending press restarts the count.
    Run_raw = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk); #1;
    check_val("midreset_run", int'(run4), 1);
    @(negedge Clk);
    Reset = 1'b0;
    wait_level(0, 1'b0, e);
    check_val("midreset_fall_edge", e, 6);
    tick(2);
    Run_raw = 1'b1;
    tick(12);

    // Single-cycle debounce instance: fall at edge 3 with one pulse.
    base_c = cp_cnt[1];
    SW_raw = 10'b0000110011;
    Continue_raw = 1'b0;
    wait_level(3, 1'b0, e);
    check_val("d1_fall_edge", e, 3);
    check_val("d1_sw", int'(sw1), 10'h033);
    tick(6);
    check_val("d1_pulses", cp_cnt[1] - base_c, 1);
    Continue_raw = 1'b1;
    tick(6);

    // Randomized traffic with variable hold times and occasional resets.
    repeat (400) begin
      Reset        = ($urandom_range(0, 63) == 0);
      Run_raw      = 1'($urandom_range(0, 1));
      Continue_raw = 1'($urandom_range(0, 1));
      SW_raw       = SWW'($urandom);
      tick($urandom_range(1, 8));
    end
    Reset = 1'b0;
    tick(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog t=%0t actual=timeout required=finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
